// File: rtl/score_pkg.sv
// score_pkg: shared constants and types for the score_keeper block.
// Holds the per-size bubble values, the death penalty, datapath widths
// and the roll-up FSM state encoding.
`timescale 1ns/1ps
package score_pkg;

    // Width of every score value seen outside the block.
    localparam int SCORE_W = 16;

    // Signed width of the event sum. It has headroom for MAX_SCORE plus the
    // largest single-cycle gain, and also holds the worst negative result.
    localparam int SUM_W = 18;

    // Points per bubble size. Smaller bubbles are harder to hit, so they
    // score more.
    localparam logic [SCORE_W-1:0] HIT_POINTS [0:3] = '{
        SCORE_W'(200), SCORE_W'(150), SCORE_W'(100), SCORE_W'(50)
    };

    // Points removed when the player loses a life.
    localparam int DEATH_PENALTY = 300;

    // Roll-up animation states.
    typedef enum logic {
        IDLE,
        ROLL
    } roll_state_e;

endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: scoring events into the block and score outputs
// toward the seven-segment digit splitter. The master drives events;
// the slave (score_keeper) drives the scores and status flags.
`timescale 1ns/1ps
interface score_keeper_if;
    import score_pkg::*;

    logic               clear;
    logic               hit_valid;
    logic [1:0]         hit_size;
    logic               bonus_valid;
    logic [9:0]         bonus_in;
    logic               death_valid;
    logic [SCORE_W-1:0] target_score;
    logic [SCORE_W-1:0] display_score;
    logic               busy;
    logic               saturated;

    modport master (
        output clear, hit_valid, hit_size, bonus_valid, bonus_in, death_valid,
        input  target_score, display_score, busy, saturated
    );

    modport slave (
        input  clear, hit_valid, hit_size, bonus_valid, bonus_in, death_valid,
        output target_score, display_score, busy, saturated
    );

endinterface

// File: rtl/score_tick_gen.sv
// score_tick_gen: free-running divider that counts 0..TICK_DIV-1 and
// pulses tick_o for one cycle on the terminal count. Only instantiated
// when SCORE_ROLLUP_EN is defined. TICK_DIV must be at least 2.
`timescale 1ns/1ps
module score_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter wraps on its own; only reset and game restart realign it.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/score_keeper.sv
// score_keeper: accumulates per-frame scoring events into a target score
// clamped to 0..MAX_SCORE, and drives a display score for the 4-digit
// seven-segment splitter.
// Build option SCORE_ROLLUP_EN: when defined, the display score counts up
// toward the target on divider ticks; when undefined, the display is the
// target delayed by one cycle and busy is held low.
`timescale 1ns/1ps
module score_keeper
    import score_pkg::*;
#(
    parameter int MAX_SCORE   = 9999,
    parameter int TICK_DIV    = 500000,
    parameter int FAST_THRESH = 10
) (
    input  logic          clk,
    input  logic          reset,
    score_keeper_if.slave bus
);

    localparam logic signed [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0]      MAX_VAL = SCORE_W'(MAX_SCORE);

    logic [SCORE_W-1:0]      target_q, target_d;
    logic                    sat_q;
    logic signed [SUM_W-1:0] delta, sum;
    logic [SCORE_W-1:0]      display_q;

    // Sum all events of this cycle and clamp the result into 0..MAX_SCORE.
    // NOTE: every signal written here gets a value on every path (defaults
    // or full if/else chains), so no latch is inferred.
    always_comb begin
        delta = '0;
        if (bus.hit_valid) begin
            delta = delta + $signed({{(SUM_W-SCORE_W){1'b0}}, HIT_POINTS[bus.hit_size]});
        end
        if (bus.bonus_valid) begin
            delta = delta + $signed({{(SUM_W-10){1'b0}}, bus.bonus_in});
        end
        if (bus.death_valid) begin
            delta = delta - $signed(SUM_W'(DEATH_PENALTY));
        end
        sum = $signed({{(SUM_W-SCORE_W){1'b0}}, target_q}) + delta;
        if (sum < 0) begin
            target_d = '0;
        end else if (sum > MAX_SUM) begin
            target_d = MAX_VAL;
        end else begin
            target_d = sum[SCORE_W-1:0];
        end
    end

    // Target score and saturation flag; restart wins over any event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '0;
            sat_q    <= 1'b0;
        end else if (bus.clear) begin
            target_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            sat_q    <= (target_d == MAX_VAL);
        end
    end

`ifdef SCORE_ROLLUP_EN
    localparam logic [SCORE_W-1:0] FAST_VAL  = SCORE_W'(FAST_THRESH);
    localparam logic [SCORE_W-1:0] STEP_FAST = SCORE_W'(10);
    localparam logic [SCORE_W-1:0] STEP_SLOW = SCORE_W'(1);

    roll_state_e        state_q, state_d;
    logic [SCORE_W-1:0] display_d;
    logic [SCORE_W-1:0] gap;
    logic               tick;

    score_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .clear_i (bus.clear),
        .tick_o  (tick)
    );

    // Roll-up FSM: climb toward the target on ticks, snap down at once.
    always_comb begin
        state_d   = state_q;
        display_d = display_q;
        gap       = target_q - display_q;
        case (state_q)
            IDLE: begin
                if (display_q < target_q) begin
                    state_d = ROLL;
                end else if (display_q > target_q) begin
                    display_d = target_q;
                end
            end
            ROLL: begin
                if (display_q >= target_q) begin
                    // Target fell to or below the display: no roll-down.
                    display_d = target_q;
                    state_d   = IDLE;
                end else if (tick) begin
                    // A 10-point step is only taken when it cannot overshoot.
                    if (gap >= FAST_VAL && gap >= STEP_FAST) begin
                        display_d = display_q + STEP_FAST;
                    end else begin
                        display_d = display_q + STEP_SLOW;
                    end
                    if (display_d == target_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and display register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            display_q <= '0;
        end else if (bus.clear) begin
            state_q   <= IDLE;
            display_q <= '0;
        end else begin
            state_q   <= state_d;
            display_q <= display_d;
        end
    end

    assign bus.busy = (state_q == ROLL);
`else
    // Divider settings only matter for the animated display.
    logic unused_cfg;
    assign unused_cfg = ^{TICK_DIV, FAST_THRESH};

    // Display follows the target one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_q <= '0;
        end else if (bus.clear) begin
            display_q <= '0;
        end else begin
            display_q <= target_q;
        end
    end

    assign bus.busy = 1'b0;
`endif

    assign bus.target_score  = target_q;
    assign bus.display_score = display_q;
    assign bus.saturated     = sat_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed checks for score_keeper with TICK_DIV=4.
// The sequence follows whichever SCORE_ROLLUP_EN build is compiled.
`timescale 1ns/1ps
module tb_score_keeper;
    import score_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    score_keeper_if bus ();

    score_keeper #(
        .MAX_SCORE   (9999),
        .TICK_DIV    (4),
        .FAST_THRESH (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of events, then return inputs to idle.
    task automatic pulse(input logic clr, input logic hv, input logic [1:0] hs,
                         input logic bv, input logic [9:0] bi, input logic dv);
        bus.clear       = clr;
        bus.hit_valid   = hv;
        bus.hit_size    = hs;
        bus.bonus_valid = bv;
        bus.bonus_in    = bi;
        bus.death_valid = dv;
        cyc();
        bus.clear       = 1'b0;
        bus.hit_valid   = 1'b0;
        bus.hit_size    = 2'd0;
        bus.bonus_valid = 1'b0;
        bus.bonus_in    = 10'd0;
        bus.death_valid = 1'b0;
    endtask

    // Wait (bounded) until display matches target with busy low.
    task automatic settle(input int budget);
        int n = 0;
        while ((bus.busy !== 1'b0 || bus.display_score !== bus.target_score) && n < budget) begin
            cyc();
            n++;
        end
    endtask

    // Wait (bounded) for the next display change and check the step.
    task automatic expect_step(input string tag, input logic [15:0] exp_disp, input logic exp_busy);
        logic [15:0] prev;
        int n = 0;
        prev = bus.display_score;
        while (bus.display_score === prev && n < 40) begin
            cyc();
            n++;
        end
        check({tag, "_disp"}, bus.display_score, exp_disp);
        check({tag, "_busy"}, bus.busy, exp_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.clear       = 1'b0;
        bus.hit_valid   = 1'b0;
        bus.hit_size    = 2'd0;
        bus.bonus_valid = 1'b0;
        bus.bonus_in    = 10'd0;
        bus.death_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        check("rst_target", bus.target_score, 16'd0);
        check("rst_display", bus.display_score, 16'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_sat", bus.saturated, 1'b0);
        reset = 1'b0;
        cyc();

`ifdef SCORE_ROLLUP_EN
        // Smallest bubble-value hit: 50 points, rolled up in steps of 10.
        pulse(1'b0, 1'b1, 2'd3, 1'b0, 10'd0, 1'b0);
        check("hit3_target", bus.target_score, 16'd50);
        check("hit3_disp_lag", bus.display_score, 16'd0);
        expect_step("roll10", 16'd10, 1'b1);
        expect_step("roll20", 16'd20, 1'b1);
        expect_step("roll30", 16'd30, 1'b1);
        expect_step("roll40", 16'd40, 1'b1);
        expect_step("roll50", 16'd50, 1'b0);
        cyc();
        check("roll_hold", bus.display_score, 16'd50);
`else
        // Hit size 1 gives 150; display follows one cycle behind.
        pulse(1'b0, 1'b1, 2'd1, 1'b0, 10'd0, 1'b0);
        check("hit1_target", bus.target_score, 16'd150);
        check("hit1_disp_lag", bus.display_score, 16'd0);
        check("hit1_busy", bus.busy, 1'b0);
        cyc();
        check("hit1_disp", bus.display_score, 16'd150);
        check("hit1_busy2", bus.busy, 1'b0);
`endif

        // Restart has priority over a same-cycle hit.
        pulse(1'b1, 1'b1, 2'd0, 1'b0, 10'd0, 1'b0);
        check("clr_target", bus.target_score, 16'd0);
        check("clr_display", bus.display_score, 16'd0);
        check("clr_busy", bus.busy, 1'b0);

        // All three events together: 200 + 1000 - 300.
        pulse(1'b0, 1'b1, 2'd0, 1'b1, 10'd1000, 1'b1);
        check("combo_target", bus.target_score, 16'd900);
        settle(2000);
        check("combo_display", bus.display_score, 16'd900);
        check("combo_busy", bus.busy, 1'b0);

        // Build up to 9900, then saturate at 9999.
        pulse(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0);
        repeat (9) pulse(1'b0, 1'b0, 2'd0, 1'b1, 10'd1000, 1'b0);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 10'd900, 1'b0);
        check("pre_sat_target", bus.target_score, 16'd9900);
        check("pre_sat_flag", bus.saturated, 1'b0);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 10'd1023, 1'b0);
        check("sat_target", bus.target_score, 16'd9999);
        check("sat_flag", bus.saturated, 1'b1);
        pulse(1'b0, 1'b1, 2'd2, 1'b0, 10'd0, 1'b0);
        check("sat_hold_target", bus.target_score, 16'd9999);
        check("sat_hold_flag", bus.saturated, 1'b1);
        pulse(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 1'b1);
        check("desat_target", bus.target_score, 16'd9699);
        check("desat_flag", bus.saturated, 1'b0);
        check("desat_display_cap", (bus.display_score <= 16'd9999), 1'b1);

        // Death from 100 clamps to 0; display blanks on the following edge.
        pulse(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0);
        pulse(1'b0, 1'b1, 2'd2, 1'b0, 10'd0, 1'b0);
        check("t100_target", bus.target_score, 16'd100);
        settle(400);
        check("t100_display", bus.display_score, 16'd100);
        pulse(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 1'b1);
        check("death_clamp_target", bus.target_score, 16'd0);
        check("death_disp_lag", bus.display_score, 16'd100);
        cyc();
        check("death_display", bus.display_score, 16'd0);
        check("death_busy", bus.busy, 1'b0);

`ifdef SCORE_ROLLUP_EN
        // Gap of 15: one fast step, then single steps near the threshold.
        pulse(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 10'd15, 1'b0);
        check("g15_target", bus.target_score, 16'd15);
        expect_step("g15_10", 16'd10, 1'b1);
        expect_step("g15_11", 16'd11, 1'b1);
        expect_step("g15_12", 16'd12, 1'b1);
        expect_step("g15_13", 16'd13, 1'b1);
        expect_step("g15_14", 16'd14, 1'b1);
        expect_step("g15_15", 16'd15, 1'b0);

        // Death mid-roll at display 30 of 50: display snaps to 0.
        pulse(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0);
        pulse(1'b0, 1'b1, 2'd3, 1'b0, 10'd0, 1'b0);
        for (int n = 0; n < 100 && bus.display_score !== 16'd30; n++) cyc();
        check("mid_disp30", bus.display_score, 16'd30);
        check("mid_busy", bus.busy, 1'b1);
        pulse(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 1'b1);
        check("mid_death_target", bus.target_score, 16'd0);
        cyc();
        check("mid_death_display", bus.display_score, 16'd0);
        check("mid_death_busy", bus.busy, 1'b0);

        // Asynchronous reset mid-roll, between clock edges.
        pulse(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0);
        pulse(1'b0, 1'b1, 2'd3, 1'b0, 10'd0, 1'b0);
        for (int n = 0; n < 100 && bus.display_score !== 16'd20; n++) cyc();
        check("ares_pre_disp", bus.display_score, 16'd20);
`else
        // Asynchronous reset between clock edges.
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 10'd500, 1'b0);
        cyc();
        check("ares_pre_disp", bus.display_score, 16'd500);
`endif
        #2;
        reset = 1'b1;
        #1;
        check("ares_target", bus.target_score, 16'd0);
        check("ares_display", bus.display_score, 16'd0);
        check("ares_busy", bus.busy, 1'b0);
        check("ares_sat", bus.saturated, 1'b0);
        #1;
        reset = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sequential score accumulator for the game.
- Collects per-frame scoring events: bubble hit, level-complete bonus, player death penalty.
- Keeps a saturating decimal-range target score and drives an animated display score to the 4-digit seven-segment digit splitter downstream.
- The display output feeds that splitter's 16-bit integer input directly; 0 blanks the display.

Parameters:
- MAX_SCORE, 9999, saturation ceiling; fits 4 decimal digits.
- TICK_DIV, 500000, clk cycles per roll-up step (10 ms at 50 MHz); must be >= 2.
- FAST_THRESH, 10, remaining gap at or above which roll-up steps by 10 instead of 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous game-restart; zeroes all score state
- hit_valid  in  1  one-cycle pulse: bubble popped
- hit_size  in  2  size of popped bubble, 0 = smallest, 3 = largest
- bonus_valid  in  1  one-cycle pulse: level completed
- bonus_in  in  10  time-left bonus points, 0..1023
- death_valid  in  1  one-cycle pulse: player lost a life
- target_score  out  16  accumulated score
- display_score  out  16  animated score to the seven-segment splitter
- busy  out  1  high while display_score < target_score
- saturated  out  1  high while target_score == MAX_SCORE

Behaviour:
- Reset (async, active-high): target_score = 0, display_score = 0, tick counter = 0, FSM = IDLE, busy = 0, saturated = 0.
- clear (sync) has the same effect as reset on the next edge and has priority over every event that cycle.
- Event sum each cycle, computed in 18-bit signed arithmetic:
  - delta = (hit_valid ? HIT_POINTS[hit_size] : 0) + (bonus_valid ? bonus_in : 0) - (death_valid ? DEATH_PENALTY : 0).
  - next_target = clamp(target_score + delta, 0, MAX_SCORE).
  - Simultaneous events are all applied in the same cycle. Nothing is queued and nothing is lost.
- Latency: an event sampled on edge n is visible on target_score after edge n (1 cycle).
- saturated is registered from next_target == MAX_SCORE.
- Tick counter: free-runs 0..TICK_DIV-1 and wraps. tick = (counter == TICK_DIV-1). It is reset by reset and clear only.
- FSM states: IDLE, ROLL.
  - IDLE: when display_score < target_score, go to ROLL. When display_score > target_score (penalty case), load display_score = target_score immediately (no roll-down) and stay in IDLE.
  - ROLL: on each tick, if gap >= FAST_THRESH, display += 10, else display += 1, where gap = target - display. Go to IDLE when display == target after the step.
  - ROLL: if target drops below display mid-roll, load display = target and go to IDLE on that edge.
  - ROLL: an increase of target mid-roll simply extends the roll.
  - The step never overshoots target.
- busy = (FSM == ROLL), registered.
- display_score never exceeds MAX_SCORE.

Optional Feature:
- Macro: SCORE_ROLLUP_EN.
- Defined: roll-up animation as described above.
- Undefined:
  - FSM and tick counter are removed.
  - display_score is a register loaded with target_score every cycle (display lags target by one cycle).
  - busy is tied to 0.
  - TICK_DIV and FAST_THRESH are unused.

Decomposition:
- Package score_pkg holds:
  - HIT_POINTS[0:3] = 200, 150, 100, 50 (smaller bubbles score more).
  - DEATH_PENALTY = 300.
  - SCORE_W = 16.
  - The IDLE/ROLL enum typedef.
- One sub-module, score_tick_gen: parameterised TICK_DIV divider with clear input and one-cycle tick output. It is instantiated only under SCORE_ROLLUP_EN.

Test Plan (bench uses TICK_DIV=4, FAST_THRESH=10, SCORE_ROLLUP_EN defined unless stated):
- Reset released, one hit_valid with hit_size=3 -> target_score=50 one cycle later. display_score reaches 50 after 5 ticks (10,20,30,40,50). busy high throughout, low after the final step.
- Same-cycle hit_valid size 0 + bonus_valid bonus_in=1000 + death_valid, from target=0 -> target=900 (200+1000-300).
- From target=9900, bonus_in=1023 -> target_score=9999, saturated=1. A further hit keeps target at 9999.
- From target=100, display settled: death_valid -> target clamps to 0, display_score=0 on the following edge, busy=0 (seven-segment blanks).
- Mid-roll at display=30 of target 50: death_valid -> target=0, display jumps to 0, FSM back in IDLE. Assert reset asynchronously mid-roll -> all outputs 0 with no clock edge.
- SCORE_ROLLUP_EN undefined: hit size 1 -> target=150 at edge n+1, display=150 at edge n+2, busy stuck 0.
